// File: rtl/ddr3_controller.sv
// ddr3_controller
//   DDR3 SDRAM power-up / initialisation / refresh sequencer. Walks the
//   RESET# -> CKE -> MRS2/3/1/0 -> ZQCL bring-up sequence, raises init_done,
//   then issues an auto-refresh every T_REFI. No data path, no user port.
//
// Ports
//   clk           in   system clock (sole domain)
//   reset         in   asynchronous, active-high
//   ddr3_reset_n  out  DRAM RESET#
//   ddr3_cke      out  clock enable
//   ddr3_cs_n     out  chip select       | command pins, {cs,ras,cas,we}
//   ddr3_ras_n    out  row strobe        |
//   ddr3_cas_n    out  column strobe     |
//   ddr3_we_n     out  write enable      |
//   ddr3_ba       out  bank address
//   ddr3_addr     out  address bus
//   ddr3_odt      out  on-die termination (always 0)
//   init_done     out  sticky 1 once initialisation completed
//
// Every output is registered. Each state is timed by a down-counter loaded
// with the state length on entry; the state's command (if any) is driven on
// the entry edge, so it occupies the first of the state's cycles.
module ddr3_controller #(
    parameter int          CLK_PERIOD = 10,
    parameter int          T_RESET_NS = 200000,
    parameter int          T_CKE_NS   = 500000,
    parameter int          T_XPR_NS   = 360,
    parameter int          T_REFI_NS  = 7800,
    parameter int          T_RFC_NS   = 160,
    parameter int          T_MRD      = 4,
    parameter int          T_MOD      = 12,
    parameter int          T_ZQINIT   = 512,
    parameter logic [13:0] MR0_VAL    = 14'h0520,
    parameter logic [13:0] MR1_VAL    = 14'h0004,
    parameter logic [13:0] MR2_VAL    = 14'h0000,
    parameter logic [13:0] MR3_VAL    = 14'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ddr3_reset_n,
    output logic        ddr3_cke,
    output logic        ddr3_cs_n,
    output logic        ddr3_ras_n,
    output logic        ddr3_cas_n,
    output logic        ddr3_we_n,
    output logic [2:0]  ddr3_ba,
    output logic [13:0] ddr3_addr,
    output logic        ddr3_odt,
    output logic        init_done
);

    function automatic int clamp1(input int c);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int ns2cyc(input int ns);
        return clamp1((ns + CLK_PERIOD - 1) / CLK_PERIOD);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int RST_CYC  = ns2cyc(T_RESET_NS);
    localparam int CKE_CYC  = ns2cyc(T_CKE_NS);
    localparam int XPR_CYC  = ns2cyc(T_XPR_NS);
    localparam int REFI_CYC = ns2cyc(T_REFI_NS);
    localparam int RFC_CYC  = ns2cyc(T_RFC_NS);
    localparam int MRD_CYC  = clamp1(T_MRD);
    localparam int MOD_CYC  = clamp1(T_MOD);
    localparam int ZQ_CYC   = clamp1(T_ZQINIT);

    localparam int MAX_CYC  = max2(max2(max2(RST_CYC, CKE_CYC), max2(XPR_CYC, REFI_CYC)),
                                   max2(max2(RFC_CYC, MRD_CYC), max2(MOD_CYC, ZQ_CYC)));
    localparam int CW       = $clog2(MAX_CYC + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DES  = 4'b1111;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    typedef enum logic [3:0] {
        RST_WAIT, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0, ZQCL, IDLE, REF_WAIT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            expire;
    logic            rstn_n, cke_n, done_n;
    logic [3:0]      cmd_n;
    logic [2:0]      ba_n;
    logic [13:0]     addr_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_WAIT;
            cnt          <= '0;
            ddr3_reset_n <= 1'b0;
            ddr3_cke     <= 1'b0;
            {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= CMD_DES;
            ddr3_ba      <= '0;
            ddr3_addr    <= '0;
            ddr3_odt     <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ddr3_reset_n <= rstn_n;
            ddr3_cke     <= cke_n;
            {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= cmd_n;
            ddr3_ba      <= ba_n;
            ddr3_addr    <= addr_n;
            ddr3_odt     <= 1'b0;
            init_done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt - 1'b1;
        expire  = (cnt == CW'(1));
        rstn_n  = ddr3_reset_n;
        cke_n   = ddr3_cke;
        done_n  = init_done;
        cmd_n   = CMD_NOP;
        ba_n    = '0;
        addr_n  = '0;

        case (state)
            RST_WAIT: begin
                // The counter comes out of reset at 0, so the first cycle after
                // release loads the remaining RST_CYC-1 cycles.
                if (cnt == '0 && RST_CYC > 1) begin
                    cnt_n = CW'(RST_CYC - 1);
                end else if (expire || cnt == '0) begin
                    state_n = CKE_WAIT;
                    cnt_n   = CW'(CKE_CYC);
                    rstn_n  = 1'b1;
                end
            end
            CKE_WAIT: if (expire) begin
                state_n = XPR;
                cnt_n   = CW'(XPR_CYC);
                cke_n   = 1'b1;
            end
            XPR: if (expire) begin
                state_n = MRS2;
                cnt_n   = CW'(MRD_CYC);
                cmd_n   = CMD_MRS;
                ba_n    = 3'd2;
                addr_n  = MR2_VAL;
            end
            MRS2: if (expire) begin
                state_n = MRS3;
                cnt_n   = CW'(MRD_CYC);
                cmd_n   = CMD_MRS;
                ba_n    = 3'd3;
                addr_n  = MR3_VAL;
            end
            MRS3: if (expire) begin
                state_n = MRS1;
                cnt_n   = CW'(MRD_CYC);
                cmd_n   = CMD_MRS;
                ba_n    = 3'd1;
                addr_n  = MR1_VAL;
            end
            MRS1: if (expire) begin
                state_n = MRS0;
                cnt_n   = CW'(MOD_CYC);
                cmd_n   = CMD_MRS;
                ba_n    = 3'd0;
                addr_n  = MR0_VAL;
            end
            MRS0: if (expire) begin
                state_n = ZQCL;
                cnt_n   = CW'(ZQ_CYC);
                cmd_n   = CMD_ZQCL;
                addr_n  = 14'h0400;     // A10=1 selects ZQ long calibration
            end
            ZQCL: if (expire) begin
                state_n = IDLE;
                cnt_n   = CW'(REFI_CYC);
                done_n  = 1'b1;
            end
            IDLE: if (expire) begin
                // No bank is ever opened, so REF needs no preceding PRECHARGE.
                state_n = REF_WAIT;
                cnt_n   = CW'(RFC_CYC);
                cmd_n   = CMD_REF;
            end
            REF_WAIT: if (expire) begin
                state_n = IDLE;
                cnt_n   = CW'(REFI_CYC);
            end
            default: begin
                state_n = RST_WAIT;
                cnt_n   = '0;
            end
        endcase

        // Chip deselected until CKE is high; NOP fills every idle cycle after.
        if (!cke_n) cmd_n = CMD_DES;
    end

endmodule

// File: tb/tb_ddr3_controller.sv
module tb_ddr3_controller;

    localparam int CLK_PERIOD = 10;

    function automatic int cyc(input int ns);
        int c;
        c = (ns + CLK_PERIOD - 1) / CLK_PERIOD;
        return (c < 1) ? 1 : c;
    endfunction

    // Schedule, in clocks after reset release, derived from the timing rules.
    localparam int R_C    = cyc(200);
    localparam int CKE_C  = cyc(500);
    localparam int XPR_C  = cyc(100);
    localparam int REFI_C = cyc(400);
    localparam int RFC_C  = cyc(160);
    localparam int MRD_C  = 4;
    localparam int MOD_C  = 12;
    localparam int ZQ_C   = 8;
    localparam int T_RSTN = R_C;
    localparam int T_CKE  = T_RSTN + CKE_C;
    localparam int T_MR2  = T_CKE + XPR_C;
    localparam int T_MR3  = T_MR2 + MRD_C;
    localparam int T_MR1  = T_MR3 + MRD_C;
    localparam int T_MR0  = T_MR1 + MRD_C;
    localparam int T_ZQ   = T_MR0 + MOD_C;
    localparam int T_DONE = T_ZQ + ZQ_C;

    typedef struct packed {
        logic        rstn;
        logic        cke;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        init;
        logic        odt;
    } outs_t;

    typedef struct {
        int    t;
        outs_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ddr3_reset_n, ddr3_cke, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
    logic [2:0]  ddr3_ba;
    logic [13:0] ddr3_addr;
    logic        ddr3_odt, init_done;

    int errors = 0;
    int checks = 0;
    int t = 0;

    always #5 clk = ~clk;

    ddr3_controller #(
        .CLK_PERIOD(10), .T_RESET_NS(200), .T_CKE_NS(500), .T_XPR_NS(100),
        .T_ZQINIT(8), .T_REFI_NS(400), .T_RFC_NS(160)
    ) dut (
        .clk(clk), .reset(reset),
        .ddr3_reset_n(ddr3_reset_n), .ddr3_cke(ddr3_cke),
        .ddr3_cs_n(ddr3_cs_n), .ddr3_ras_n(ddr3_ras_n),
        .ddr3_cas_n(ddr3_cas_n), .ddr3_we_n(ddr3_we_n),
        .ddr3_ba(ddr3_ba), .ddr3_addr(ddr3_addr),
        .ddr3_odt(ddr3_odt), .init_done(init_done)
    );

    function automatic outs_t mk(input logic rstn, input logic cke, input logic [3:0] cmd,
                                 input logic [2:0] ba, input logic [13:0] addr, input logic init);
        outs_t o;
        o.rstn = rstn; o.cke = cke; o.cmd = cmd; o.ba = ba;
        o.addr = addr; o.init = init; o.odt = 1'b0;
        return o;
    endfunction

    // Reference: expected pins t clocks after release, from the schedule.
    function automatic outs_t exp_at(input int tt, input logic in_rst);
        outs_t e;
        int    k;
        e = mk(1'b0, 1'b0, 4'b1111, 3'd0, 14'h0, 1'b0);
        if (!in_rst) begin
            e.rstn = (tt >= T_RSTN);
            e.cke  = (tt >= T_CKE);
            e.cmd  = e.cke ? 4'b0111 : 4'b1111;
            e.init = (tt >= T_DONE);
            if (tt == T_MR2) begin e.cmd = 4'b0000; e.ba = 3'd2; end
            if (tt == T_MR3) begin e.cmd = 4'b0000; e.ba = 3'd3; end
            if (tt == T_MR1) begin e.cmd = 4'b0000; e.ba = 3'd1; e.addr = 14'h0004; end
            if (tt == T_MR0) begin e.cmd = 4'b0000; e.ba = 3'd0; e.addr = 14'h0520; end
            if (tt == T_ZQ)  begin e.cmd = 4'b0110; e.addr = 14'h0400; end
            if (e.init) begin
                k = tt - T_DONE;
                if (k >= REFI_C && ((k - REFI_C) % (REFI_C + RFC_C)) == 0) e.cmd = 4'b0001;
            end
        end
        return e;
    endfunction

    function automatic outs_t actual();
        return mk(ddr3_reset_n, ddr3_cke, {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n},
                  ddr3_ba, ddr3_addr, init_done) | {29'b0, ddr3_odt};
    endfunction

    task automatic compare(input string name, input outs_t got, input outs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0d got rstn=%b cke=%b cmd=%b ba=%0d addr=%h init=%b odt=%b want rstn=%b cke=%b cmd=%b ba=%0d addr=%h init=%b odt=%b",
                     name, t, got.rstn, got.cke, got.cmd, got.ba, got.addr, got.init, got.odt,
                     want.rstn, want.cke, want.cmd, want.ba, want.addr, want.init, want.odt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) t = 0; else t = t + 1;
        @(negedge clk);
        compare("model", actual(), exp_at(t, reset));
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 2000) begin
            tick();
            guard++;
        end
        checks++;
        if (t != target) begin
            errors++;
            $display("FAIL reach t=%0d required %0d", t, target);
        end
    endtask

    // Reset applied asynchronously between edges; pins must follow at once.
    task automatic assert_reset();
        #2 reset = 1'b1;
        #1 compare("async_rst", actual(), mk(1'b0, 1'b0, 4'b1111, 3'd0, 14'h0, 1'b0));
    endtask

    task automatic release_reset();
        #2 reset = 1'b0;
    endtask

    vec_t tbl[20];

    initial begin
        outs_t g;
        tbl[0]  = '{19,  mk(0, 0, 4'b1111, 3'd0, 14'h0000, 0)};
        tbl[1]  = '{20,  mk(1, 0, 4'b1111, 3'd0, 14'h0000, 0)};
        tbl[2]  = '{69,  mk(1, 0, 4'b1111, 3'd0, 14'h0000, 0)};
        tbl[3]  = '{70,  mk(1, 1, 4'b0111, 3'd0, 14'h0000, 0)};
        tbl[4]  = '{79,  mk(1, 1, 4'b0111, 3'd0, 14'h0000, 0)};
        tbl[5]  = '{80,  mk(1, 1, 4'b0000, 3'd2, 14'h0000, 0)};
        tbl[6]  = '{81,  mk(1, 1, 4'b0111, 3'd0, 14'h0000, 0)};
        tbl[7]  = '{84,  mk(1, 1, 4'b0000, 3'd3, 14'h0000, 0)};
        tbl[8]  = '{88,  mk(1, 1, 4'b0000, 3'd1, 14'h0004, 0)};
        tbl[9]  = '{92,  mk(1, 1, 4'b0000, 3'd0, 14'h0520, 0)};
        tbl[10] = '{103, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 0)};
        tbl[11] = '{104, mk(1, 1, 4'b0110, 3'd0, 14'h0400, 0)};
        tbl[12] = '{111, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 0)};
        tbl[13] = '{112, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 1)};
        tbl[14] = '{151, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 1)};
        tbl[15] = '{152, mk(1, 1, 4'b0001, 3'd0, 14'h0000, 1)};
        tbl[16] = '{153, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 1)};
        tbl[17] = '{207, mk(1, 1, 4'b0111, 3'd0, 14'h0000, 1)};
        tbl[18] = '{208, mk(1, 1, 4'b0001, 3'd0, 14'h0000, 1)};
        tbl[19] = '{264, mk(1, 1, 4'b0001, 3'd0, 14'h0000, 1)};

        // Hold reset 20 clocks; every tick checks reset values.
        repeat (20) tick();
        release_reset();

        // Table-driven bring-up and refresh schedule.
        for (int i = 0; i < 20; i++) begin
            run_until(tbl[i].t);
            compare("tbl", actual(), tbl[i].o);
        end

        // Abort during the MRS phase, then full sequence again.
        assert_reset();
        repeat (3) tick();
        release_reset();
        run_until(86);
        assert_reset();
        repeat (2) tick();
        release_reset();
        run_until(T_MR0);
        compare("mr0_again", actual(), mk(1, 1, 4'b0000, 3'd0, 14'h0520, 0));
        run_until(T_ZQ);
        compare("zq_again", actual(), mk(1, 1, 4'b0110, 3'd0, 14'h0400, 0));
        run_until(T_DONE);
        g = actual();
        checks++;
        if (g.init !== 1'b1) begin
            errors++;
            $display("FAIL init_again got=%b required=1", g.init);
        end

        // Randomized reset pulses at arbitrary points, checked against the model.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 320);
            assert_reset();
            repeat ($urandom_range(1, 4)) tick();
            release_reset();
            repeat (n) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
